// File: rtl/rca.sv
// ============================================================================
// Module   : rca
// Brief    : Registered WIDTH-bit ripple-carry adder, {co,s} = a + b + ci.
//            Define RCA_INREG_EN to add an input register stage (latency 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_ci;

`ifdef RCA_INREG_EN
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_ci;

  // en freezes this stage together with the output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_ci <= 1'b0;
    end else if (en) begin
      r_a  <= a;
      r_b  <= b;
      r_ci <= ci;
    end
  end

  assign w_a  = r_a;
  assign w_b  = r_b;
  assign w_ci = r_ci;
`else
  assign w_a  = a;
  assign w_b  = b;
  assign w_ci = ci;
`endif

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;

  assign w_c[0] = w_ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_sum[i]  = w_a[i] ^ w_b[i] ^ w_c[i];
    assign w_c[i+1]  = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
  end

  logic [WIDTH-1:0] r_s;
  logic             r_co;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s  <= '0;
      r_co <= 1'b0;
    end else if (en) begin
      r_s  <= w_sum;
      r_co <= w_c[WIDTH];
    end
  end

  assign s  = r_s;
  assign co = r_co;

endmodule

`default_nettype wire

// File: tb/tb_rca.sv
// ============================================================================
// Module   : tb_rca
// Brief    : Self-checking bench for rca (WIDTH=4), arithmetic model plus
//            directed literal vectors and an exhaustive sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rca;

`ifdef RCA_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] a;
  logic [3:0] b;
  logic       ci;
  logic [3:0] s;
  logic       co;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  rca #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .a   (a),
    .b   (b),
    .ci  (ci),
    .s   (s),
    .co  (co)
  );

  always #5 clk = ~clk;

  // Model: the sum is plain integer addition; m_in is the result sampled one
  // enabled edge earlier, used only when the input stage is present.
  logic [4:0] m_in;
  logic [4:0] m_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in  <= 5'd0;
      m_out <= 5'd0;
    end else if (en) begin
      m_in  <= 5'(a) + 5'(b) + 5'(ci);
      m_out <= (LAT == 2) ? m_in : 5'(a) + 5'(b) + 5'(ci);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({co, s} !== m_out) begin
        n_err++;
        $display("FAIL model t=%0t: got {co,s}=%h want %h (a=%h b=%h ci=%b en=%b rst=%b)",
                 $time, {co, s}, m_out, a, b, ci, en, rst);
      end
    end
  end

  task automatic lit(input string nm, input logic [4:0] want);
    n_cmp++;
    if ({co, s} !== want) begin
      n_err++;
      $display("FAIL %s: got {co,s}=%h want %h", nm, {co, s}, want);
    end
  endtask

  task automatic apply(input logic [3:0] va, input logic [3:0] vb, input logic vci);
    a  = va;
    b  = vb;
    ci = vci;
    repeat (LAT) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    a   = 4'h7;
    b   = 4'h7;
    ci  = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lit("reset_hold", 5'h00);
      @(negedge clk);
    end

    rst = 1'b0;
    repeat (LAT) @(negedge clk);
    lit("reset_release", 5'h0F);

    apply(4'h0, 4'h0, 1'b0); lit("zero",        5'h00);
    apply(4'h5, 4'h4, 1'b0); lit("no_carry",    5'h09);
    apply(4'hF, 4'hF, 1'b0); lit("full_ripple", 5'h1E);
    apply(4'hF, 4'hF, 1'b1); lit("full_ci",     5'h1F);
    apply(4'hF, 4'h0, 1'b1); lit("chain_ci",    5'h10);

    en = 1'b0;
    a  = 4'h1;
    b  = 4'h1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      lit("en_hold", 5'h10);
    end

    // Asynchronous reset asserted mid-cycle discards the pending result
    en = 1'b1;
    a  = 4'h3;
    b  = 4'h3;
    ci = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    lit("async_reset", 5'h00);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    lit("discarded", 5'h00);
    en = 1'b1;
    apply(4'h2, 4'h1, 1'b0); lit("after_reset", 5'h03);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v  = 9'(i);
      a  = v[8:5];
      b  = v[4:1];
      ci = v[0];
      en = (i % 7) != 3;
      @(negedge clk);
    end
    en = 1'b1;
    repeat (LAT) @(negedge clk);
    lit("sweep_last", 5'h1F);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
